// File: rtl/mem_io_resp_pkg.sv
// rtl/mem_io_resp_pkg.sv - shared widths, I/O page constants and address decode helper
package mem_io_resp_pkg;

  localparam int         MEM_ADD_W = 32;
  localparam int         MEM_DAT_W = 8;
  localparam logic [1:0] IO_PAGE   = 2'b11;
  localparam logic [2:0] IO_UART   = 3'h0;
  localparam logic [2:0] IO_CYC    = 3'h4;

  typedef enum logic [1:0] {
    RGN_RAM,
    RGN_NULL,
    RGN_IO
  } region_e;

  // mem_a[17:16] selects the region; the 0x2xxxx window is a sink.
  function automatic region_e decode_region(input logic [1:0] page);
    if (page == IO_PAGE) begin
      return RGN_IO;
    end else if (!page[1]) begin
      return RGN_RAM;
    end
    return RGN_NULL;
  endfunction

endpackage

// File: rtl/byte_fifo.sv
// rtl/byte_fifo.sv - power-of-two byte FIFO with occupancy count
module byte_fifo
  import mem_io_resp_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [MEM_DAT_W-1:0]     din,
  input  logic                     pop,
  output logic [MEM_DAT_W-1:0]     dout,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [MEM_DAT_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]        rd_q;
  logic [AW-1:0]        wr_q;
  logic [AW:0]          cnt_q;
  logic                 do_push;
  logic                 do_pop;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == (AW + 1)'(DEPTH));
  assign count   = cnt_q;
  assign dout    = mem_q[rd_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Storage is left unreset; only pointers and count define validity.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_q] <= din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) begin
        wr_q <= wr_q + 1'b1;
      end
      if (do_pop) begin
        rd_q <= rd_q + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/mem_io_resp.sv
// rtl/mem_io_resp.sv - cpu byte-bus responder: RAM, I/O page, UART TX/RX FIFOs (RX under MEM_IO_RESP_RX_EN)
module mem_io_resp
  import mem_io_resp_pkg::*;
#(
  parameter int RAM_ADDR_W = 17,
  parameter int TX_DEPTH   = 8,
  parameter int RX_DEPTH   = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [MEM_ADD_W-1:0] mem_a,
  input  logic [MEM_DAT_W-1:0] mem_dout,
  input  logic                 mem_wr,
  output logic [MEM_DAT_W-1:0] mem_din,
  output logic                 io_buffer_full,
  output logic [MEM_DAT_W-1:0] tx_data,
  output logic                 tx_valid,
  input  logic                 tx_ready,
  input  logic [MEM_DAT_W-1:0] rx_data,
  input  logic                 rx_valid,
  output logic                 rx_ready,
  output logic                 program_stop
);

  localparam int TX_CW = $clog2(TX_DEPTH) + 1;

  region_e              rgn;
  logic                 io_base;
  logic [2:0]           io_off;
  logic                 rd_req;
  logic                 wr_ram;
  logic                 rd_ram;
  logic                 io_wr_uart;
  logic                 io_wr_stop;
  logic                 io_rd_uart;
  logic                 io_rd_cyc;
  logic                 tx_push;
  logic [MEM_DAT_W-1:0] tx_din;
  logic                 tx_empty;
  logic                 tx_full;
  logic [TX_CW-1:0]     tx_count;
  logic [MEM_DAT_W-1:0] rx_head;
  logic                 rx_empty;
  logic [MEM_DAT_W-1:0] rdata_d;

  logic [MEM_DAT_W-1:0] ram [2**RAM_ADDR_W];
  logic [MEM_DAT_W-1:0] ram_rd_q;
  logic [MEM_DAT_W-1:0] io_rd_q;
  logic                 din_ram_q;
  logic                 io_full_q;
  logic                 stop_q;
  logic [31:0]          cyc_q;
  logic [31:0]          snap_q;
  logic                 unused_addr;

  assign unused_addr = ^mem_a[MEM_ADD_W-1:18];

  assign rgn        = decode_region(mem_a[17:16]);
  assign io_base    = (mem_a[15:3] == 13'd0);
  assign io_off     = mem_a[2:0];
  assign rd_req     = en && !mem_wr;
  assign wr_ram     = en && mem_wr && (rgn == RGN_RAM);
  assign rd_ram     = rd_req && (rgn == RGN_RAM);
  assign io_wr_uart = en && mem_wr && (rgn == RGN_IO) && io_base && (io_off == IO_UART);
  assign io_wr_stop = en && mem_wr && (rgn == RGN_IO) && io_base && (io_off == IO_CYC);
  assign io_rd_uart = rd_req && (rgn == RGN_IO) && io_base && (io_off == IO_UART);
  assign io_rd_cyc  = rd_req && (rgn == RGN_IO) && io_base && (io_off == IO_CYC);

  // A stop write enqueues a 0x00 terminator; zero data bytes are never stored.
  assign tx_push  = !tx_full && ((io_wr_uart && (mem_dout != '0)) || io_wr_stop);
  assign tx_din   = io_wr_stop ? '0 : mem_dout;
  assign tx_valid = !tx_empty;

  byte_fifo #(.DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk   (clk),
    .rst_n (rst),
    .push  (tx_push),
    .din   (tx_din),
    .pop   (tx_valid && tx_ready),
    .dout  (tx_data),
    .empty (tx_empty),
    .full  (tx_full),
    .count (tx_count)
  );

`ifdef MEM_IO_RESP_RX_EN
  logic                    rx_full;
  logic [$clog2(RX_DEPTH):0] rx_count_unused;

  assign rx_ready = !rx_full;

  byte_fifo #(.DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk   (clk),
    .rst_n (rst),
    .push  (rx_valid && !rx_full),
    .din   (rx_data),
    .pop   (io_rd_uart && !rx_empty),
    .dout  (rx_head),
    .empty (rx_empty),
    .full  (rx_full),
    .count (rx_count_unused)
  );
`else
  logic unused_rx;

  assign unused_rx = ^{rx_data, rx_valid};
  assign rx_ready  = 1'b0;
  assign rx_head   = '0;
  assign rx_empty  = 1'b1;
`endif

  always_comb begin
    rdata_d = '0;
    if ((rgn == RGN_IO) && io_base) begin
      case (io_off)
        IO_UART: rdata_d = rx_empty ? '0 : rx_head;
        IO_CYC:  rdata_d = cyc_q[7:0];
        3'd5:    rdata_d = snap_q[15:8];
        3'd6:    rdata_d = snap_q[23:16];
        3'd7:    rdata_d = snap_q[31:24];
        default: rdata_d = '0;
      endcase
    end
  end

  // RAM read port kept free of reset so the array maps onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_ram) begin
      ram[mem_a[RAM_ADDR_W-1:0]] <= mem_dout;
    end
    if (rd_ram) begin
      ram_rd_q <= ram[mem_a[RAM_ADDR_W-1:0]];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      din_ram_q <= 1'b0;
      io_rd_q   <= '0;
      io_full_q <= 1'b0;
      stop_q    <= 1'b0;
      cyc_q     <= '0;
      snap_q    <= '0;
    end else begin
      io_full_q <= (tx_count >= TX_CW'(TX_DEPTH - 2));
      if (rd_req) begin
        din_ram_q <= (rgn == RGN_RAM);
        io_rd_q   <= rdata_d;
      end
      if (io_rd_cyc) begin
        snap_q <= cyc_q;
      end
      if (io_wr_stop) begin
        stop_q <= 1'b1;
      end
      if (en) begin
        cyc_q <= cyc_q + 32'd1;
      end
    end
  end

  assign mem_din        = din_ram_q ? ram_rd_q : io_rd_q;
  assign io_buffer_full = io_full_q;
  assign program_stop   = stop_q;

endmodule

// File: doc/mem_io_resp.md
Name: mem_io_resp

Overview:
- Memory-side responder for the cpu byte bus (mem_a / mem_dout / mem_wr / mem_din / io_buffer_full).
- Implements the RAM array and the memory-mapped I/O page at 0x30000.
- Buffers UART TX bytes and exposes io_buffer_full back to the cpu.
- Sits between the cpu top and the UART/host link. Serves cpu loads one cycle after request.

Parameters:
- RAM_ADDR_W, 17, RAM byte-address width (128 KB).
- TX_DEPTH, 8, TX byte FIFO entries (power of two, >=4).
- RX_DEPTH, 8, RX byte FIFO entries (power of two, >=2).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- en  in  1  cpu enable; bus requests are ignored while low.
- mem_a  in  32  cpu address; only [17:0] is decoded.
- mem_dout  in  8  cpu write data.
- mem_wr  in  1  1 = write, 0 = read.
- mem_din  out  8  read data to cpu, registered.
- io_buffer_full  out  1  TX FIFO near-full, registered.
- tx_data  out  8  TX FIFO head byte.
- tx_valid  out  1  TX FIFO non-empty.
- tx_ready  in  1  UART accepts tx_data this cycle.
- rx_data  in  8  incoming byte.
- rx_valid  in  1  push rx_data this cycle.
- rx_ready  out  1  RX FIFO not full.
- program_stop  out  1  sticky; set by a write to 0x30004.

Behaviour:
- Decode
  - I/O when mem_a[17:16]==2'b11.
  - RAM when mem_a[17]==0, indexed by mem_a[RAM_ADDR_W-1:0].
  - 0x20000-0x2FFFF: writes dropped, reads return 0x00.
- Every cycle with en=1 is a bus transaction. mem_wr=0 is a read, mem_wr=1 is a write.
- While en=0:
  - no read, write, pop or counter increment occurs;
  - mem_din holds its value;
  - TX drain and RX push continue.
- RAM
  - Read: mem_din <= ram[a] at the next rising edge, so data is valid the cycle after the request.
  - Write: takes effect at the edge; no wait.
  - Read-after-write to the same address in the next cycle returns the new byte.
- I/O write 0x30000
  - Push mem_dout to the TX FIFO; 0x00 is ignored.
  - If the FIFO is full, the byte is dropped.
- I/O write 0x30004
  - Set program_stop=1 (sticky until reset).
  - Push 0x00 terminator to the TX FIFO if not full.
- I/O read 0x30000
  - RX FIFO non-empty: mem_din <= head, pop.
  - RX FIFO empty: mem_din <= 0x00.
- Cycle counter
  - 32-bit cyc, reset 0, +1 every cycle en=1, wraps at 2^32.
- I/O read 0x30004
  - mem_din <= cyc[7:0].
  - snap <= cyc (all 32 bits) at the same edge.
- I/O reads 0x30005, 0x30006, 0x30007: return snap[15:8], snap[23:16], snap[31:24].
- Other I/O offsets: reads return 0x00, writes dropped.
- io_buffer_full
  - Registered version of tx_count >= TX_DEPTH-2.
  - The two-entry headroom absorbs cpu reaction latency.
- TX drain
  - tx_valid = !tx_empty.
  - Pop when tx_valid && tx_ready.
  - Simultaneous push and pop: count unchanged.
  - A push to an empty FIFO is visible on tx_valid the next cycle.
- RX
  - Push when rx_valid && rx_ready; rx_ready = !rx_full.
  - A simultaneous push and pop on an empty FIFO does not return the new byte (returns 0x00).
- Reset (rst=0, async)
  - mem_din=0, io_buffer_full=0, tx_valid=0, rx_ready=1 after release, program_stop=0.
  - Both FIFOs are emptied; cyc=0, snap=0.
  - RAM contents are not reset.
  - Reset mid-transaction discards any pending read.

Optional Feature:
- Macro MEM_IO_RESP_RX_EN.
- Defined: RX FIFO and rx_data / rx_valid / rx_ready are functional as above.
- Undefined:
  - No RX FIFO is built.
  - rx_ready is tied 0 and rx_data / rx_valid are ignored.
  - Read of 0x30000 always returns 0x00.

Decomposition:
- Shared header:
  - IO_PAGE (2'b11);
  - offsets IO_UART=3'h0 and IO_CYC=3'h4;
  - widths MEM_ADD_W and MEM_DAT_W (existing).
- Sub-module byte_fifo (parameter DEPTH):
  - ports: push, din, pop, dout, empty, full, count;
  - instantiated once for TX and, under the macro, once for RX.

Test Plan:
- RAM: write 0x5A @0x00123 (cycle n); read 0x00123 at n+1 -> mem_din=0x5A at n+2.
- UART TX, tx_ready=0:
  - write 0x41,0x00,0x42,... to 0x30000 -> only non-zero bytes enqueue;
  - io_buffer_full rises when the 6th byte is stored (depth 8);
  - 9th byte dropped;
  - tx_ready=1 drains 0x41,0x42,... in order.
- Counter: en=1 for 1000 cycles, then read 0x30004..0x30007 -> bytes form snap = cyc at the 0x30004 read, unaffected by later increments.
- Stop: write any byte to 0x30004 -> program_stop=1 next cycle, 0x00 appears on tx_data, and program_stop stays 1 for the rest of the run.
- RX (macro on): push 0x31,0x32 -> two reads of 0x30000 return 0x31, 0x32, third read returns 0x00.
- Pause and reset:
  - en=0 with mem_wr=1 to RAM -> RAM unchanged, cyc frozen.
  - Assert rst mid-drain -> tx_valid=0 and io_buffer_full=0 immediately (asynchronous).
